// File: rtl/vscale_mem_arbiter.sv
// vscale_mem_arbiter: shares one pipelined single-ported memory bus between
// the instruction fetch port and the data port. Data accesses win by default.
// A streak limit guarantees that instruction fetch still gets a slot.
//
// Bus handshake: an address phase is offered while mem_en is high (valid).
// It is taken on a rising edge where mem_ready is also high (ready). The
// data phase of that transfer then runs until a later edge with mem_ready
// high. mem_error is meaningful only in a cycle where mem_ready is high.
module vscale_mem_arbiter #(
  parameter int MAX_DMEM_STREAK = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          imem_addr,
  output logic                 imem_wait,
  output logic [31:0]          imem_rdata,
  output logic                 imem_badmem_e,
  input  logic                 dmem_en,
  input  logic                 dmem_wen,
  input  logic [2:0]           dmem_size,
  input  logic [31:0]          dmem_addr,
  input  logic [31:0]          dmem_wdata_delayed,
  output logic [31:0]          dmem_rdata,
  output logic                 dmem_wait,
  output logic                 dmem_badmem_e,
  output logic                 mem_en,
  output logic                 mem_wen,
  output logic [2:0]           mem_size,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  input  logic                 mem_error,
  output logic [CNT_WIDTH-1:0] dmem_stall_cnt
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DMEM_STREAK);
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // Everything the arbiter remembers about the transfer in its data phase.
  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   wen;
  } dphase_t;

  dphase_t     dphase;
  logic [3:0]  streak;
  owner_e      grant;
  logic        accept;
  logic        i_pending;
  logic        d_pending;

  // Address-phase grant and the request driven onto the bus.
  always_comb begin
    grant    = (dmem_en && (streak != STREAK_MAX)) ? OWNER_D : OWNER_I;
    mem_en   = 1'b0;
    mem_wen  = 1'b0;
    mem_size = 3'b000;
    mem_addr = 32'h0;
    if (!reset) begin
      mem_en = 1'b1;
      if (grant == OWNER_D) begin
        mem_wen  = dmem_wen;
        mem_size = dmem_size;
        mem_addr = dmem_addr;
      end else begin
        mem_size = SIZE_WORD;
        mem_addr = imem_addr;
      end
    end
  end

  assign accept    = mem_en && mem_ready;
  assign i_pending = dphase.valid && (dphase.owner == OWNER_I);
  assign d_pending = dphase.valid && (dphase.owner == OWNER_D);

  // Route responses, errors, store data and stalls back to the owning port.
  always_comb begin
    imem_rdata    = 32'h0;
    dmem_rdata    = 32'h0;
    imem_badmem_e = 1'b0;
    dmem_badmem_e = 1'b0;
    mem_wdata     = 32'h0;
    imem_wait     = 1'b0;
    dmem_wait     = 1'b0;
    if (!reset) begin
      imem_rdata    = mem_rdata;
      dmem_rdata    = mem_rdata;
      imem_badmem_e = i_pending && mem_ready && mem_error;
      dmem_badmem_e = d_pending && mem_ready && mem_error;
      if (d_pending && dphase.wen) begin
        mem_wdata = dmem_wdata_delayed;
      end
      imem_wait = (grant != OWNER_I) || !mem_ready || (i_pending && !mem_ready);
      dmem_wait = (dmem_en && ((grant != OWNER_D) || !mem_ready)) ||
                  (d_pending && !mem_ready);
    end
  end

  // Data-phase ownership: captured on accept, dropped when the bus goes idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dphase <= '0;
    end else if (accept) begin
      dphase.valid <= 1'b1;
      dphase.owner <= grant;
      dphase.wen   <= mem_wen;
    end else if (mem_ready) begin
      dphase.valid <= 1'b0;
    end
  end

  // Consecutive data grants, saturating at the limit; any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= 4'd0;
    end else if (accept) begin
      if (grant == OWNER_D) begin
        streak <= (streak >= STREAK_MAX) ? STREAK_MAX : streak + 4'd1;
      end else begin
        streak <= 4'd0;
      end
    end
  end

  // Free-running count of data-port stall cycles, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_stall_cnt <= '0;
    end else if (dmem_wait) begin
      dmem_stall_cnt <= dmem_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Testbench for vscale_mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_vscale_mem_arbiter;

  localparam int          MAX = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr = 32'h0;
  logic        imem_wait;
  logic [31:0] imem_rdata;
  logic        imem_badmem_e;
  logic        dmem_en = 1'b0;
  logic        dmem_wen = 1'b0;
  logic [2:0]  dmem_size = 3'b010;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata_delayed = 32'h0;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;
  logic        mem_en;
  logic        mem_wen;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b1;
  logic        mem_error = 1'b0;
  logic [31:0] dmem_stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  vscale_mem_arbiter #(.MAX_DMEM_STREAK(MAX), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_wait(imem_wait), .imem_rdata(imem_rdata),
    .imem_badmem_e(imem_badmem_e),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait), .dmem_badmem_e(dmem_badmem_e),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_error(mem_error), .dmem_stall_cnt(dmem_stall_cnt)
  );

  // Clock.
  always #5 clk = ~clk;

  // Bus slave: returns a word derived from the last accepted address.
  logic [31:0] bus_addr_q = 32'h0;
  always @(posedge clk) if (mem_en && mem_ready) bus_addr_q <= mem_addr;
  assign mem_rdata = bus_addr_q ^ KEY;

  // Reference model: pending data phase as a queue of codes
  // (0 = fetch, 1 = data read, 2 = data write), grant streak and stall count.
  int          pend_q[$];
  int          m_streak = 0;
  logic [31:0] m_cnt = 32'h0;

  function automatic bit f_dwin();
    return !reset && dmem_en && (m_streak < MAX);
  endfunction

  function automatic int f_code();
    return (pend_q.size() == 0) ? -1 : pend_q[0];
  endfunction

  function automatic bit f_imem_wait();
    if (reset) return 1'b0;
    return f_dwin() || !mem_ready;
  endfunction

  function automatic bit f_dmem_wait();
    if (reset) return 1'b0;
    return (dmem_en && (!f_dwin() || !mem_ready)) || (f_code() >= 1 && !mem_ready);
  endfunction

  // Model update on each clock edge.
  always @(posedge clk) begin
    if (reset) begin
      pend_q.delete();
      m_streak <= 0;
      m_cnt    <= 32'h0;
    end else begin
      if (f_dmem_wait()) m_cnt <= m_cnt + 32'd1;
      if (mem_ready) begin
        pend_q.delete();
        pend_q.push_back(f_dwin() ? (dmem_wen ? 2 : 1) : 0);
        m_streak <= f_dwin() ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
      end
    end
  end

  // Advance to just after the next rising edge, ready to drive inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %0h exp 0", mem_en); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %0h exp 0", mem_addr); end
    checks++; if ({imem_wait, dmem_wait} !== 2'b00) begin errors++; $display("FAIL reset_waits got %0b exp 00", {imem_wait, dmem_wait}); end
    checks++; if (dmem_stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %0h exp 0", dmem_stall_cnt); end
    checks++; if ({imem_badmem_e, dmem_badmem_e} !== 2'b00) begin errors++; $display("FAIL reset_bad got %0b exp 00", {imem_badmem_e, dmem_badmem_e}); end
  endtask

  task automatic test_fetch();
    logic [31:0] addrs [4];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hC;
    for (int i = 0; i < 4; i++) begin
      cyc();
      reset = 1'b0; dmem_en = 1'b0; mem_ready = 1'b1; mem_error = 1'b0;
      imem_addr = addrs[i];
      @(negedge clk);
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL fetch_mem_en[%0d] got %0h exp 1", i, mem_en); end
      checks++; if (mem_addr !== addrs[i]) begin errors++; $display("FAIL fetch_addr[%0d] got %0h exp %0h", i, mem_addr, addrs[i]); end
      checks++; if (imem_wait !== 1'b0) begin errors++; $display("FAIL fetch_wait[%0d] got %0h exp 0", i, imem_wait); end
      if (i > 0) begin
        checks++; if (imem_rdata !== (addrs[i-1] ^ KEY)) begin errors++; $display("FAIL fetch_rdata[%0d] got %0h exp %0h", i, imem_rdata, addrs[i-1] ^ KEY); end
      end
    end
  endtask

  task automatic test_dmem_pulse();
    cyc();
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'b010; dmem_addr = 32'h100;
    imem_addr = 32'h10;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL pulse_addr got %0h exp 100", mem_addr); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL pulse_wen got %0h exp 0", mem_wen); end
    checks++; if (imem_wait !== 1'b1) begin errors++; $display("FAIL pulse_imem_wait got %0h exp 1", imem_wait); end
    checks++; if (dmem_wait !== 1'b0) begin errors++; $display("FAIL pulse_dmem_wait got %0h exp 0", dmem_wait); end
    cyc();
    dmem_en = 1'b0;
    @(negedge clk);
    checks++; if (dmem_rdata !== (32'h100 ^ KEY)) begin errors++; $display("FAIL pulse_drdata got %0h exp %0h", dmem_rdata, 32'h100 ^ KEY); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL pulse_next_addr got %0h exp 10", mem_addr); end
    checks++; if (imem_wait !== 1'b0) begin errors++; $display("FAIL pulse_imem_free got %0h exp 0", imem_wait); end
  endtask

  task automatic test_streak();
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      reset = 1'b0; dmem_en = 1'b1; dmem_wen = 1'b0;
      dmem_addr = 32'h300 + 32'(4 * i);
      imem_addr = 32'h1000 + 32'(4 * i);
      exp_q.push_back((i % 5 == 4) ? imem_addr : dmem_addr);
      @(negedge clk);
      begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++; if (mem_addr !== e) begin errors++; $display("FAIL streak_grant[%0d] got %0h exp %0h", i, mem_addr, e); end
      end
      checks++; if (dmem_wait !== (i % 5 == 4)) begin errors++; $display("FAIL streak_dwait[%0d] got %0h exp %0h", i, dmem_wait, (i % 5 == 4)); end
    end
    cyc();
    dmem_en = 1'b0;
    @(negedge clk);
    checks++; if (dmem_stall_cnt !== 32'd2) begin errors++; $display("FAIL streak_cnt got %0d exp 2", dmem_stall_cnt); end
  endtask

  task automatic test_store();
    cyc();
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_size = 3'b010; dmem_addr = 32'h200;
    dmem_wdata_delayed = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL store_wen got %0h exp 1", mem_wen); end
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL store_addr got %0h exp 200", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL store_wdata_early got %0h exp 0", mem_wdata); end
    cyc();
    dmem_en = 1'b0; dmem_wen = 1'b0;
    @(negedge clk);
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata got %0h exp deadbeef", mem_wdata); end
    cyc();
    @(negedge clk);
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL store_wdata_late got %0h exp 0", mem_wdata); end
  endtask

  task automatic test_wait_error();
    cyc();
    imem_addr = 32'h40; mem_ready = 1'b1; mem_error = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      imem_addr = 32'h44; mem_ready = 1'b0;
      @(negedge clk);
      checks++; if (imem_wait !== 1'b1) begin errors++; $display("FAIL stall_iwait[%0d] got %0h exp 1", i, imem_wait); end
      checks++; if (mem_addr !== 32'h44) begin errors++; $display("FAIL stall_addr[%0d] got %0h exp 44", i, mem_addr); end
      checks++; if (dmem_wait !== 1'b0) begin errors++; $display("FAIL stall_dwait[%0d] got %0h exp 0", i, dmem_wait); end
    end
    cyc();
    mem_ready = 1'b1; mem_error = 1'b1;
    @(negedge clk);
    checks++; if (imem_badmem_e !== 1'b1) begin errors++; $display("FAIL err_ibad got %0h exp 1", imem_badmem_e); end
    checks++; if (dmem_badmem_e !== 1'b0) begin errors++; $display("FAIL err_dbad got %0h exp 0", dmem_badmem_e); end
    cyc();
    mem_error = 1'b0; imem_addr = 32'h48;
    @(negedge clk);
    checks++; if (imem_badmem_e !== 1'b0) begin errors++; $display("FAIL err_pulse got %0h exp 0", imem_badmem_e); end
  endtask

  task automatic test_reset_mid();
    cyc();
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h500; mem_ready = 1'b1;
    cyc();
    dmem_en = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (dmem_wait !== 1'b1) begin errors++; $display("FAIL rmid_pending got %0h exp 1", dmem_wait); end
    cyc();
    reset = 1'b1; dmem_en = 1'b1; mem_error = 1'b1;
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rmid_mem_en got %0h exp 0", mem_en); end
    checks++; if ({imem_wait, dmem_wait} !== 2'b00) begin errors++; $display("FAIL rmid_waits got %0b exp 00", {imem_wait, dmem_wait}); end
    checks++; if (dmem_badmem_e !== 1'b0) begin errors++; $display("FAIL rmid_dbad got %0h exp 0", dmem_badmem_e); end
    cyc();
    @(negedge clk);
    checks++; if (dmem_stall_cnt !== 32'h0) begin errors++; $display("FAIL rmid_cnt got %0h exp 0", dmem_stall_cnt); end
    cyc();
    reset = 1'b0; dmem_en = 1'b0; mem_ready = 1'b1; mem_error = 1'b1;
    @(negedge clk);
    checks++; if ({imem_badmem_e, dmem_badmem_e} !== 2'b00) begin errors++; $display("FAIL rmid_abandon got %0b exp 00", {imem_badmem_e, dmem_badmem_e}); end
    mem_error = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic        e_dwin;
      logic [31:0] e_addr;
      logic [2:0]  e_size;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
      cyc();
      reset              = ($urandom_range(0, 39) == 0);
      dmem_en            = ($urandom_range(0, 9) < 6);
      dmem_wen           = 1'($urandom_range(0, 1));
      dmem_size          = 3'($urandom_range(0, 7));
      dmem_addr          = $urandom;
      imem_addr          = $urandom;
      dmem_wdata_delayed = $urandom;
      mem_ready          = ($urandom_range(0, 3) != 0);
      mem_error          = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      e_dwin  = f_dwin();
      e_addr  = reset ? 32'h0 : (e_dwin ? dmem_addr : imem_addr);
      e_size  = reset ? 3'b000 : (e_dwin ? dmem_size : 3'b010);
      e_wdata = (!reset && f_code() == 2) ? dmem_wdata_delayed : 32'h0;
      e_rdata = reset ? 32'h0 : mem_rdata;
      checks++; if (mem_en !== !reset) begin errors++; $display("FAIL rnd_mem_en[%0d] got %0h exp %0h", i, mem_en, !reset); end
      checks++; if (mem_wen !== (e_dwin && dmem_wen)) begin errors++; $display("FAIL rnd_mem_wen[%0d] got %0h exp %0h", i, mem_wen, e_dwin && dmem_wen); end
      checks++; if (mem_size !== e_size) begin errors++; $display("FAIL rnd_mem_size[%0d] got %0h exp %0h", i, mem_size, e_size); end
      checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_mem_addr[%0d] got %0h exp %0h", i, mem_addr, e_addr); end
      checks++; if (mem_wdata !== e_wdata) begin errors++; $display("FAIL rnd_mem_wdata[%0d] got %0h exp %0h", i, mem_wdata, e_wdata); end
      checks++; if (imem_wait !== f_imem_wait()) begin errors++; $display("FAIL rnd_imem_wait[%0d] got %0h exp %0h", i, imem_wait, f_imem_wait()); end
      checks++; if (dmem_wait !== f_dmem_wait()) begin errors++; $display("FAIL rnd_dmem_wait[%0d] got %0h exp %0h", i, dmem_wait, f_dmem_wait()); end
      checks++; if (imem_badmem_e !== (!reset && f_code() == 0 && mem_ready && mem_error)) begin errors++; $display("FAIL rnd_ibad[%0d] got %0h", i, imem_badmem_e); end
      checks++; if (dmem_badmem_e !== (!reset && f_code() >= 1 && mem_ready && mem_error)) begin errors++; $display("FAIL rnd_dbad[%0d] got %0h", i, dmem_badmem_e); end
      checks++; if ({imem_rdata, dmem_rdata} !== {e_rdata, e_rdata}) begin errors++; $display("FAIL rnd_rdata[%0d] got %0h/%0h exp %0h", i, imem_rdata, dmem_rdata, e_rdata); end
      checks++; if (dmem_stall_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, dmem_stall_cnt, m_cnt); end
    end
  endtask

  // Scenario sequence and final report.
  initial begin
    test_reset();
    test_fetch();
    test_dmem_pulse();
    test_streak();
    test_store();
    test_wait_error();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
